adc_code_capture: RTL and testbench
===================================

ADC_CODE_CAPTURE -- requirements
Module: adc_code_capture

Interface
REQ-001 Parameter DATA_W, default 8: ADC code width.
REQ-002 Parameter DEPTH, default 16: output FIFO entries; SHALL be a power of two, at least 2.
REQ-003 Parameter AVG_LOG2, default 2: averaging window is 2^AVG_LOG2 samples; 0 means pass-through.
REQ-004 clk  input  1  the single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse that begins a capture.
REQ-007 num_out  input  16  averaged results per capture; sampled on an accepted start.
REQ-008 sample_en  input  1  code is valid this cycle (ADC sample strobe).
REQ-009 code  input  DATA_W  ADC output code.
REQ-010 m_data  output  DATA_W  averaged result at FIFO head.
REQ-011 m_valid  output  1  m_data valid.
REQ-012 m_ready  input  1  consumer accepts m_data.
REQ-013 busy  output  1  high in ACQ.
REQ-014 done  output  1  one-cycle pulse at capture end.
REQ-015 overflow  output  1  sticky: a result was dropped.
REQ-016 min_code, max_code  output  DATA_W each  raw-code extremes; present only with ADC_CAPTURE_MINMAX_EN.

Function
REQ-017 FSM states SHALL be IDLE, ACQ, DONE; start in IDLE -> ACQ; ACQ -> DONE in the cycle after the result count reaches the latched num_out; DONE -> IDLE after exactly one cycle.
REQ-018 done SHALL be high exactly during the DONE cycle; busy SHALL equal (state==ACQ).
REQ-019 start in ACQ or DONE SHALL be ignored; num_out=0 SHALL go IDLE -> ACQ -> DONE with no sample consumed.
REQ-020 sample_en outside ACQ SHALL be ignored.
REQ-021 In ACQ each sample_en SHALL add code into an accumulator of DATA_W+AVG_LOG2 bits and increment a window counter.
REQ-022 On the 2^AVG_LOG2-th sample the block SHALL push (acc+code)>>AVG_LOG2 (truncation, no rounding), clear the accumulator and counter, and increment the result count, all in that cycle.
REQ-023 Latency: a push into an empty FIFO SHALL give m_valid=1 on the next cycle.
REQ-024 Push while full with no pop in the same cycle SHALL drop the result and set overflow; the dropped result still counts toward num_out.
REQ-025 Push while full with a simultaneous pop (m_valid&m_ready) SHALL be accepted.
REQ-026 Pop SHALL occur on m_valid&m_ready; m_data SHALL be held stable while m_valid&!m_ready; FIFO order SHALL be preserved.
REQ-027 The FIFO SHALL keep draining in all states; start SHALL NOT flush it.
REQ-028 overflow SHALL clear only on reset or an accepted start.

Reset
REQ-029 rst SHALL asynchronously set state=IDLE, busy=0, done=0, overflow=0, m_valid=0, m_data=0, empty the FIFO, and clear the accumulator and counters.
REQ-030 rst mid-capture SHALL discard the partial window and all queued results.
REQ-031 Under ADC_CAPTURE_MINMAX_EN, rst SHALL set min_code to all-ones and max_code to 0.

Configuration
REQ-032 With macro ADC_CAPTURE_MINMAX_EN defined, min_code/max_code SHALL track raw codes accepted in ACQ, update the cycle after each sample, and reinitialise on an accepted start.
REQ-033 Without ADC_CAPTURE_MINMAX_EN, the min/max ports and logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-034 Shared package adc_pkg SHALL hold the FSM state typedef (IDLE/ACQ/DONE) and the default DATA_W constant.
REQ-035 The FIFO SHALL be the sub-module adc_sync_fifo (parameters DATA_W, DEPTH; push/pop/full/empty; first-word-fall-through).

Verification
REQ-036 AVG_LOG2=2, num_out=3, codes 0x10,0x12,0x14,0x16 repeated, m_ready=1 -> three results 0x13; done pulses once after the 12th sample; busy=0 afterwards.
REQ-037 AVG_LOG2=0, num_out=20, ramp 0x00..0x13, m_ready=0 -> 16 entries 0x00..0x0F held, overflow=1, done pulses; draining yields 0x00..0x0F in order.
REQ-038 AVG_LOG2=0, m_ready toggling every cycle, 40 random codes -> output sequence equals input sequence with no loss or duplication.
REQ-039 rst pulsed after 5 samples of a capture -> m_valid, busy, overflow go to 0 without a clock edge; the next capture runs normally.
REQ-040 start pulsed during ACQ and sample_en pulsed in IDLE -> no effect on num_out, the result count, or the FIFO.
REQ-041 ADC_CAPTURE_MINMAX_EN, codes 0x80,0x03,0xFE -> min_code=0x03, max_code=0xFE; a new start resets them to 0xFF/0x00.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC code capture block.
package adc_pkg;

    localparam int unsigned ADC_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        DONE = 2'd2
    } adc_state_t;

endpackage

// File: rtl/adc_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head word reads as zero while empty.
module adc_sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/adc_code_capture.sv
// ADC code capture: window-averages accepted codes and queues results in a FIFO.
// Define ADC_CAPTURE_MINMAX_EN to add raw-code min_code/max_code tracking.
module adc_code_capture
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W   = ADC_DATA_W,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       num_out,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] code,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
`ifdef ADC_CAPTURE_MINMAX_EN
    output logic [DATA_W-1:0] min_code,
    output logic [DATA_W-1:0] max_code,
`endif
    output logic              overflow
);

    localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
    localparam int unsigned WIN_W = AVG_LOG2 + 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((1 << AVG_LOG2) - 1);

    adc_state_t        r_state;
    logic [15:0]       r_num_out;
    logic [15:0]       r_res_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic [WIN_W-1:0]  r_win_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_overflow;

    logic              w_start;
    logic              w_sample;
    logic              w_win_end;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    logic [ACC_W-1:0]  w_sum;
    logic [DATA_W-1:0] w_avg;

    // Samples are only taken while results are still owed for this capture.
    assign w_start   = (r_state == IDLE) && start;
    assign w_sample  = (r_state == ACQ) && sample_en && (r_res_cnt != r_num_out);
    assign w_win_end = (r_win_cnt == WIN_LAST);
    assign w_push    = w_sample && w_win_end;
    assign w_sum     = r_acc + ACC_W'(code);
    assign w_avg     = DATA_W'(w_sum >> AVG_LOG2);
    assign w_pop     = m_ready && !w_empty;
    assign w_drop    = w_push && w_full && !w_pop;

    adc_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_avg),
        .i_pop   (m_ready),
        .o_data  (m_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_num_out  <= '0;
            r_res_cnt  <= '0;
            r_acc      <= '0;
            r_win_cnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state    <= ACQ;
                        r_busy     <= 1'b1;
                        r_num_out  <= num_out;
                        r_res_cnt  <= '0;
                        r_acc      <= '0;
                        r_win_cnt  <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                ACQ: begin
                    if (r_res_cnt == r_num_out) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_sample) begin
                        if (w_win_end) begin
                            r_acc     <= '0;
                            r_win_cnt <= '0;
                            r_res_cnt <= r_res_cnt + 1'b1;
                        end else begin
                            r_acc     <= w_sum;
                            r_win_cnt <= r_win_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign m_valid  = !w_empty;

`ifdef ADC_CAPTURE_MINMAX_EN
    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min <= '1;
            r_max <= '0;
        end else if (w_start) begin
            r_min <= '1;
            r_max <= '0;
        end else if (w_sample) begin
            if (code < r_min) begin
                r_min <= code;
            end
            if (code > r_max) begin
                r_max <= code;
            end
        end
    end

    assign min_code = r_min;
    assign max_code = r_max;
`endif

endmodule

// File: tb/tb_adc_code_capture.sv
// Scoreboard bench for adc_code_capture: lane 0 averages over 4 samples, lane 1 passes codes through.
module tb_adc_code_capture;

    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        start_s     [2];
    logic [15:0] num_out_s   [2];
    logic        sample_en_s [2];
    logic [7:0]  code_s      [2];
    logic        m_ready_s   [2];
    logic [7:0]  m_data_s    [2];
    logic        m_valid_s   [2];
    logic        busy_s      [2];
    logic        done_s      [2];
    logic        ovf_s       [2];
`ifdef ADC_CAPTURE_MINMAX_EN
    logic [7:0]  min_s       [2];
    logic [7:0]  max_s       [2];
`endif

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int unsigned AL  = (g == 0) ? 2 : 0;
        localparam int          WIN = 1 << AL;

        adc_code_capture #(
            .DATA_W   (8),
            .DEPTH    (DEPTH),
            .AVG_LOG2 (AL)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_s[g]),
            .num_out   (num_out_s[g]),
            .sample_en (sample_en_s[g]),
            .code      (code_s[g]),
            .m_data    (m_data_s[g]),
            .m_valid   (m_valid_s[g]),
            .m_ready   (m_ready_s[g]),
            .busy      (busy_s[g]),
            .done      (done_s[g]),
`ifdef ADC_CAPTURE_MINMAX_EN
            .min_code  (min_s[g]),
            .max_code  (max_s[g]),
`endif
            .overflow  (ovf_s[g])
        );

        // Reference model: mode 0 idle, 1 capturing, 2 finishing; q holds results not yet consumed.
        int q[$];
        int mode    = 0;
        int nout    = 0;
        int res     = 0;
        int win_n   = 0;
        int win_sum = 0;
        int occ     = 0;
        int ovf     = 0;
        int mn      = 255;
        int mx      = 0;
        int pops    = 0;
        int dones   = 0;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                mode = 0; nout = 0; res = 0; win_n = 0; win_sum = 0;
                occ = 0; ovf = 0; mn = 255; mx = 0;
                q.delete();
            end else begin : m_step
                bit pop_now;
                bit push_now;
                int val;
                int c;
                pop_now  = m_ready_s[g] && (occ > 0);
                push_now = 1'b0;
                val      = 0;
                case (mode)
                    0: if (start_s[g]) begin
                        mode = 1; nout = int'(num_out_s[g]); res = 0;
                        win_n = 0; win_sum = 0; ovf = 0; mn = 255; mx = 0;
                    end
                    1: if (res == nout) begin
                        mode = 2;
                    end else if (sample_en_s[g]) begin
                        c = int'(code_s[g]);
                        win_sum += c;
                        win_n++;
                        if (c < mn) mn = c;
                        if (c > mx) mx = c;
                        if (win_n == WIN) begin
                            push_now = 1'b1;
                            val      = win_sum / WIN;
                            res++;
                            win_n   = 0;
                            win_sum = 0;
                        end
                    end
                    default: mode = 0;
                endcase
                if (push_now) begin
                    if (occ == DEPTH && !pop_now) begin
                        ovf = 1;
                    end else begin
                        q.push_back(val);
                        occ++;
                    end
                end
                if (pop_now) occ--;
            end
        end

        always @(negedge clk) begin
            if (!rst) begin
                check($sformatf("lane%0d busy", g), int'(busy_s[g]), int'(mode == 1));
                check($sformatf("lane%0d done", g), int'(done_s[g]), int'(mode == 2));
                check($sformatf("lane%0d overflow", g), int'(ovf_s[g]), ovf);
                check($sformatf("lane%0d m_valid", g), int'(m_valid_s[g]), int'(occ > 0));
`ifdef ADC_CAPTURE_MINMAX_EN
                check($sformatf("lane%0d min_code", g), int'(min_s[g]), mn);
                check($sformatf("lane%0d max_code", g), int'(max_s[g]), mx);
`endif
                if (done_s[g]) dones++;
                if (m_valid_s[g]) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL lane%0d m_data: got 0x%0h, expected no output", g, m_data_s[g]);
                    end else begin
                        check($sformatf("lane%0d m_data", g), int'(m_data_s[g]), q[0]);
                        if (m_ready_s[g]) begin
                            void'(q.pop_front());
                            pops++;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int ln, input int n);
        start_s[ln]   = 1'b1;
        num_out_s[ln] = 16'(n);
        tick();
        start_s[ln]   = 1'b0;
    endtask

    task automatic sample(input int ln, input int c);
        sample_en_s[ln] = 1'b1;
        code_s[ln]      = 8'(c);
        tick();
        sample_en_s[ln] = 1'b0;
    endtask

    int p0, p1, d0, d1, n, cyc;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; num_out_s[i] = '0; sample_en_s[i] = 1'b0;
            code_s[i] = '0; m_ready_s[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("lane%0d reset m_data", i), int'(m_data_s[i]), 0);
            check($sformatf("lane%0d reset m_valid", i), int'(m_valid_s[i]), 0);
        end
        tick();

        // Averaging of a repeating four-code pattern.
        p0 = g_lane[0].pops; d0 = g_lane[0].dones;
        m_ready_s[0] = 1'b1;
        pulse_start(0, 3);
        for (int i = 0; i < 12; i++) sample(0, 16 + 2 * (i % 4));
        repeat (4) tick();
        check("avg result count", g_lane[0].pops - p0, 3);
        check("avg done pulses", g_lane[0].dones - d0, 1);
        check("avg busy after", int'(busy_s[0]), 0);

        // Pass-through ramp into a stalled consumer, then drain.
        p1 = g_lane[1].pops; d1 = g_lane[1].dones;
        m_ready_s[1] = 1'b0;
        pulse_start(1, 20);
        for (int i = 0; i < 20; i++) sample(1, i);
        repeat (3) tick();
        check("ramp overflow", int'(ovf_s[1]), 1);
        check("ramp head held", int'(m_data_s[1]), 0);
        check("ramp done pulses", g_lane[1].dones - d1, 1);
        m_ready_s[1] = 1'b1;
        repeat (20) tick();
        check("ramp drained", g_lane[1].pops - p1, 16);

        // Toggling consumer against random codes at matching rate.
        p1 = g_lane[1].pops;
        pulse_start(1, 40);
        n = 0; cyc = 0;
        while (n < 40 && cyc < 400) begin
            m_ready_s[1] = ~m_ready_s[1];
            if (cyc % 2 == 0 && $urandom_range(0, 3) != 0) begin
                sample_en_s[1] = 1'b1;
                code_s[1]      = 8'($urandom_range(0, 255));
                n++;
            end else begin
                sample_en_s[1] = 1'b0;
            end
            tick();
            cyc++;
        end
        sample_en_s[1] = 1'b0;
        m_ready_s[1]   = 1'b1;
        repeat (20) tick();
        check("toggle results", g_lane[1].pops - p1, 40);
        check("toggle overflow", int'(ovf_s[1]), 0);

        // Samples in idle and starts during capture are ignored.
        p0 = g_lane[0].pops;
        for (int i = 0; i < 3; i++) sample(0, 200);
        pulse_start(0, 2);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) pulse_start(0, 7);
            sample(0, $urandom_range(0, 255));
        end
        repeat (6) tick();
        check("ignore results", g_lane[0].pops - p0, 2);
        check("ignore busy", int'(busy_s[0]), 0);

        // Zero-length capture.
        p0 = g_lane[0].pops; d0 = g_lane[0].dones;
        pulse_start(0, 0);
        repeat (3) tick();
        check("zero results", g_lane[0].pops - p0, 0);
        check("zero done pulses", g_lane[0].dones - d0, 1);

        // Asynchronous reset mid-capture with queued results and overflow.
        m_ready_s[0] = 1'b0;
        m_ready_s[1] = 1'b0;
        pulse_start(1, 30);
        for (int i = 0; i < 20; i++) sample(1, i + 50);
        pulse_start(0, 5);
        for (int i = 0; i < 5; i++) sample(0, 40);
        @(negedge clk);
        check("pre-reset overflow", int'(ovf_s[1]), 1);
        check("pre-reset m_valid", int'(m_valid_s[0]), 1);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("lane%0d async m_valid", i), int'(m_valid_s[i]), 0);
            check($sformatf("lane%0d async busy", i), int'(busy_s[i]), 0);
            check($sformatf("lane%0d async overflow", i), int'(ovf_s[i]), 0);
            check($sformatf("lane%0d async m_data", i), int'(m_data_s[i]), 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        p0 = g_lane[0].pops;
        m_ready_s[0] = 1'b1;
        pulse_start(0, 2);
        for (int i = 0; i < 8; i++) sample(0, 8 * i);
        repeat (4) tick();
        check("post-reset results", g_lane[0].pops - p0, 2);

        // Random captures on both lanes with a bursty consumer.
        for (int r = 0; r < 3; r++) begin
            for (int ln = 0; ln < 2; ln++) begin
                start_s[ln]   = 1'b1;
                num_out_s[ln] = 16'($urandom_range(1, 24));
            end
            tick();
            for (int ln = 0; ln < 2; ln++) start_s[ln] = 1'b0;
            repeat (150) begin
                for (int ln = 0; ln < 2; ln++) begin
                    sample_en_s[ln] = ($urandom_range(0, 3) != 0);
                    code_s[ln]      = 8'($urandom_range(0, 255));
                    m_ready_s[ln]   = ($urandom_range(0, 2) == 0);
                end
                tick();
            end
            for (int ln = 0; ln < 2; ln++) begin
                sample_en_s[ln] = 1'b0;
                m_ready_s[ln]   = 1'b1;
            end
            repeat (40) tick();
        end

`ifdef ADC_CAPTURE_MINMAX_EN
        repeat (30) tick();
        m_ready_s[0] = 1'b1;
        pulse_start(0, 1);
        sample(0, 8'h80);
        sample(0, 8'h03);
        sample(0, 8'hFE);
        @(negedge clk);
        check("minmax min", int'(min_s[0]), 8'h03);
        check("minmax max", int'(max_s[0]), 8'hFE);
        tick();
        sample(0, 8'h50);
        repeat (4) tick();
        pulse_start(0, 0);
        @(negedge clk);
        check("minmax restart min", int'(min_s[0]), 8'hFF);
        check("minmax restart max", int'(max_s[0]), 8'h00);
        tick();
`endif

        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
